// File: rtl/lsu_pkg.sv
// Shared definitions for the LSU port arbiter.
//   - LSU opcodes (load, store, NOP)
//   - UART register window addresses seen on the LSU address bus
//   - arbiter FSM state encoding
package lsu_pkg;

  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_NOP    = 7'b0000000;

  localparam logic [31:0] UART_TX   = 32'h0000_0400;
  localparam logic [31:0] UART_RX   = 32'h0000_0404;
  localparam logic [31:0] UART_BAUD = 32'h0000_040C;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/lsu_port_arbiter_rr_pick2.sv
// Two-way round-robin picker (purely combinational).
//   valid0/valid1 : requests pending
//   last_grant    : 1 when port 1 was granted last, 0 when port 0 was
//   grant         : one-hot grant, bit N for port N; 0 when nothing is valid
module rr_pick2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      // Contention: the port that did not win last time goes first.
      grant = last_grant ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Arbiter/sequencer sharing one LSU port between the core (port 0) and a
// debug/DMA requester (port 1). One transaction is in flight at a time.
//   clk, rst_n                 : clock, async active-low reset
//   reqN_valid/opcode/addr/wdata, reqN_ready : request channels (valid/ready)
//   respN_valid/rdata/err      : one-cycle completion pulse per requester
//   lsu_opcode/address/data_in, lsu_get      : LSU command side
//   lsu_busy, lsu_data_out     : LSU status / load data
// TIMEOUT_CYCLES bounds the number of busy WAIT cycles (1..255).
module lsu_port_arbiter
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [6:0]  req0_opcode,
  input  logic [31:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [6:0]  req1_opcode,
  input  logic [31:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        resp0_valid,
  output logic [31:0] resp0_rdata,
  output logic        resp0_err,
  output logic        resp1_valid,
  output logic [31:0] resp1_rdata,
  output logic        resp1_err,
  output logic [6:0]  lsu_opcode,
  output logic [31:0] lsu_address,
  output logic [31:0] lsu_data_in,
  output logic        lsu_get,
  input  logic        lsu_busy,
  input  logic [31:0] lsu_data_out
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  arb_state_t  state_q, state_d;
  logic [6:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [1:0]  grant;
  logic        active;

  rr_pick2 u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_q),
    .grant      (grant)
  );

  always_comb begin
    // NOTE: every _d starts as its _q so no path through the case leaves a
    // variable unassigned; that is what keeps this block free of latches.
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (grant != 2'b00) begin
          owner_d = grant[1];
          op_d    = grant[1] ? req1_opcode : req0_opcode;
          addr_d  = grant[1] ? req1_addr   : req0_addr;
          wdata_d = grant[1] ? req1_wdata  : req0_wdata;
          rdata_d = 32'd0;
          // Illegal opcodes never reach the LSU; they answer straight away.
          err_d   = !is_legal_op(op_d);
          state_d = is_legal_op(op_d) ? ISSUE : RESP;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!lsu_busy) begin
          if (op_q == OP_LOAD) rdata_d = lsu_data_out;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            err_d   = 1'b1;
            rdata_d = 32'd0;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        // Remember who just finished so the other port wins the next tie.
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the payload registers are reset as well as the FSM, so the LSU
      // command bus and response data come out of reset as clean zeros.
      state_q <= IDLE;
      op_q    <= OP_NOP;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;  // "port 1 went last" => port 0 favoured after reset
      cnt_q   <= 8'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // The command bus only carries the latched request while it is in flight.
  assign active      = (state_q == ISSUE) || (state_q == WAIT);
  assign lsu_opcode  = active ? op_q    : OP_NOP;
  assign lsu_address = active ? addr_q  : 32'd0;
  assign lsu_data_in = active ? wdata_q : 32'd0;
  assign lsu_get     = (state_q == ISSUE);

  assign req0_ready  = (state_q == IDLE) && grant[0];
  assign req1_ready  = (state_q == IDLE) && grant[1];

  assign resp0_valid = (state_q == RESP) && !owner_q;
  assign resp1_valid = (state_q == RESP) &&  owner_q;
  assign resp0_rdata = resp0_valid ? rdata_q : 32'd0;
  assign resp1_rdata = resp1_valid ? rdata_q : 32'd0;
  assign resp0_err   = resp0_valid && err_q;
  assign resp1_err   = resp1_valid && err_q;

endmodule

// File: tb/tb_lsu_port_arbiter.sv
module tb_lsu_port_arbiter;
  import lsu_pkg::*;

  localparam int T = 8;
  localparam logic [6:0] OP_ILLEGAL = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [6:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_addr, req1_addr, req0_wdata, req1_wdata;
  logic        req0_ready, req1_ready;
  logic        resp0_valid, resp1_valid, resp0_err, resp1_err;
  logic [31:0] resp0_rdata, resp1_rdata;
  logic [6:0]  lsu_opcode;
  logic [31:0] lsu_address, lsu_data_in, lsu_data_out;
  logic        lsu_get, lsu_busy;

  int n_cmp = 0;
  int n_err = 0;

  lsu_port_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_opcode(req0_opcode), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_opcode(req1_opcode), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .lsu_opcode(lsu_opcode), .lsu_address(lsu_address), .lsu_data_in(lsu_data_in),
    .lsu_get(lsu_get), .lsu_busy(lsu_busy), .lsu_data_out(lsu_data_out)
  );

  always #5 clk = ~clk;

  // LSU model: a get loads a busy countdown; stores land in memory at issue,
  // loads return memory (or the UART RX register) once busy drops.
  logic [31:0] lsu_mem [16] = '{default: '0};
  logic [31:0] lat_addr = '0;
  logic [31:0] rx_reg = 32'habcd1234;
  int          busy_left = 0;
  int          busy_cfg = 0;

  always @(posedge clk) begin
    if (lsu_get) begin
      busy_left <= busy_cfg;
      lat_addr  <= lsu_address;
      if (lsu_opcode == OP_STORE) lsu_mem[lsu_address[3:0]] <= lsu_data_in;
    end else if (busy_left != 0) begin
      busy_left <= busy_left - 1;
    end
  end
  assign lsu_busy     = (busy_left != 0);
  assign lsu_data_out = (lat_addr == UART_RX) ? rx_reg : lsu_mem[lat_addr[3:0]];

  // Reference model state.
  logic [31:0] mem_m [16] = '{default: '0};
  int          last_m = 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    last_m = 1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One transaction from the next IDLE cycle to its response, checked
  // against grant rule, latency rule, data rule and LSU bus behaviour.
  task automatic do_txn(input logic v0, input logic v1,
                        input logic [6:0] op0, input logic [6:0] op1,
                        input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input int busy, input string tag);
    int w, n, k, gets, elat;
    logic [6:0]  eop;
    logic [31:0] ea, ed, erd;
    logic        legal, tmo, stable, ready_seen_busy;

    w     = (v0 && v1) ? ((last_m == 0) ? 1 : 0) : (v0 ? 0 : 1);
    eop   = (w == 1) ? op1 : op0;
    ea    = (w == 1) ? a1 : a0;
    ed    = (w == 1) ? d1 : d0;
    legal = (eop == OP_LOAD) || (eop == OP_STORE);
    tmo   = legal && (busy >= T);
    elat  = !legal ? 1 : (tmo ? T + 2 : 3 + busy);
    erd   = 32'd0;
    if (legal && !tmo && eop == OP_LOAD) erd = (ea == UART_RX) ? rx_reg : mem_m[ea[3:0]];
    if (legal && eop == OP_STORE) mem_m[ea[3:0]] = ed;

    @(posedge clk); #1;
    busy_cfg = busy;
    req0_valid = v0; req0_opcode = op0; req0_addr = a0; req0_wdata = d0;
    req1_valid = v1; req1_opcode = op1; req1_addr = a1; req1_wdata = d1;
    #1;
    n = 0;
    while (!(req0_ready || req1_ready) && n < 20) begin
      @(posedge clk); #2;
      n++;
    end
    check({tag, "/ready_wait"}, n, 0);
    check({tag, "/ready0"}, req0_ready, (w == 0));
    check({tag, "/ready1"}, req1_ready, (w == 1));

    @(posedge clk); #1;   // accept edge passed
    if (w == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
    #1;
    k = 1; gets = 0; stable = 1'b1; ready_seen_busy = 1'b0;
    while (!(resp0_valid || resp1_valid) && k < T + 10) begin
      gets += int'(lsu_get);
      if (req0_ready || req1_ready) ready_seen_busy = 1'b1;
      if (legal) begin
        if (lsu_opcode !== eop || lsu_address !== ea || lsu_data_in !== ed) stable = 1'b0;
      end else if (lsu_opcode !== OP_NOP) begin
        stable = 1'b0;
      end
      if (k == 1) check({tag, "/get_first"}, lsu_get, legal);
      @(posedge clk); #2;
      k++;
    end
    check({tag, "/latency"}, k, elat);
    check({tag, "/resp0_valid"}, resp0_valid, (w == 0));
    check({tag, "/resp1_valid"}, resp1_valid, (w == 1));
    check({tag, "/rdata"}, (w == 1) ? resp1_rdata : resp0_rdata, erd);
    check({tag, "/err"}, (w == 1) ? resp1_err : resp0_err, (!legal || tmo));
    check({tag, "/get_count"}, gets, legal);
    check({tag, "/bus_stable"}, stable, 1'b1);
    check({tag, "/no_ready_inflight"}, ready_seen_busy, 1'b0);
    check({tag, "/nop_in_resp"}, lsu_opcode, OP_NOP);
    last_m = w;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v0, v1, seen;
    logic [6:0]  o0, o1;
    logic [31:0] x0, x1;
    int r, b;

    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_opcode = '0; req1_opcode = '0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst/lsu_opcode", lsu_opcode, OP_NOP);
    check("rst/lsu_get", lsu_get, 1'b0);
    check("rst/lsu_address", lsu_address, 32'd0);
    check("rst/lsu_data_in", lsu_data_in, 32'd0);
    check("rst/ready", {req0_ready, req1_ready}, 2'b00);
    check("rst/resp", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 4'b0);
    check("rst/rdata", resp0_rdata | resp1_rdata, 32'd0);
    rst_n = 1'b1;

    // Zero-wait store, then a UART RX load with 4 busy cycles.
    do_txn(1'b1, 1'b0, OP_STORE, OP_NOP, 32'd5, 32'd0, 32'h1234abcd, 32'd0, 0, "store0");
    check("store0/lsu_mem5", lsu_mem[5], 32'h1234abcd);
    do_txn(1'b0, 1'b1, OP_NOP, OP_LOAD, 32'd0, UART_RX, 32'd0, 32'd0, 4, "load1_rx");

    // Round-robin under continuous contention, starting from reset.
    do_reset();
    for (int i = 0; i < 4; i++)
      do_txn(1'b1, 1'b1, OP_LOAD, OP_STORE, 32'd5, 32'd9, 32'h0, 32'h5a5a0000 + i, 0, "rr_both");

    do_txn(1'b1, 1'b0, OP_ILLEGAL, OP_NOP, 32'd3, 32'd0, 32'h0, 32'h0, 0, "illegal0");

    // Timeout boundary: T-1 busy cycles completes, T busy cycles aborts.
    do_txn(1'b1, 1'b0, OP_LOAD, OP_NOP, 32'd5, 32'd0, 32'h0, 32'h0, T - 1, "busy_tm1");
    do_txn(1'b0, 1'b1, OP_NOP, OP_LOAD, 32'd0, UART_RX, 32'h0, 32'h0, 200, "timeout1");
    do_txn(1'b0, 1'b1, OP_NOP, OP_LOAD, 32'd0, 32'd9, 32'h0, 32'h0, 1, "after_tmo");

    // Reset in WAIT: immediate NOP, no response for the aborted request.
    @(posedge clk); #1;
    busy_cfg = 200;
    req1_valid = 1'b1; req1_opcode = OP_LOAD; req1_addr = UART_RX;
    #1;
    check("rstwait/ready1", req1_ready, 1'b1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rstwait/pre_opcode", lsu_opcode, OP_LOAD);
    rst_n = 1'b0;
    #1;
    check("rstwait/lsu_opcode", lsu_opcode, OP_NOP);
    check("rstwait/lsu_get", lsu_get, 1'b0);
    check("rstwait/lsu_bus", lsu_address | lsu_data_in, 32'd0);
    check("rstwait/resp", {resp0_valid, resp1_valid, resp0_err, resp1_err}, 4'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    last_m = 1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #2;
      if (resp0_valid || resp1_valid) seen = 1'b1;
    end
    check("rstwait/no_resp", seen, 1'b0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      r  = $urandom_range(0, 2);
      v0 = (r != 1);
      v1 = (r != 0);
      r  = $urandom_range(0, 9);
      o0 = (r < 4) ? OP_LOAD : (r < 8) ? OP_STORE : OP_ILLEGAL;
      r  = $urandom_range(0, 9);
      o1 = (r < 4) ? OP_LOAD : (r < 8) ? OP_STORE : OP_ILLEGAL;
      x0 = 32'($urandom_range(0, 15));
      x1 = 32'($urandom_range(0, 15));
      if (o0 == OP_LOAD && $urandom_range(0, 3) == 0) x0 = UART_RX;
      if (o1 == OP_LOAD && $urandom_range(0, 3) == 0) x1 = UART_RX;
      b  = $urandom_range(0, 9);
      do_txn(v0, v1, o0, o1, x0, x1, $urandom, $urandom, b, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
